bcd_display_feeder: RTL and testbench

Upstream feeder for the 4-digit seven-segment multiplexer. Accepts a binary count (the Game of Life generation number) on a one-cycle load strobe. Converts it to packed 4-digit BCD with a sequential shift-and-add-3 (double-dabble) engine and presents the result as a stable `displayed_number`. Also generates the free-running 2-bit `digit_activating_counter` that steps the multiplexer through the four digits at the refresh rate.

---
 rtl/bcd_display_feeder.sv | 132 +++++++++++++
 tb/tb_bcd_display_feeder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_feeder.sv
// Binary-to-BCD feeder for the 4-digit seven-segment multiplexer.
// Sequential double-dabble conversion plus a free-running digit-slot refresh counter.
module bcd_display_feeder #(
   parameter int BIN_W       = 14,
   parameter int REFRESH_DIV = 100000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [BIN_W-1:0] bin_in,
   output logic             busy,
   output logic             done,
   output logic             overflow,
   output logic [15:0]      displayed_number,
   output logic [1:0]       digit_activating_counter
);

   localparam int ITER_W = $clog2(BIN_W + 1);
   localparam int PRE_W  = $clog2(REFRESH_DIV);
   localparam logic [BIN_W-1:0]  MAX_VAL   = BIN_W'(9999);
   localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(BIN_W - 1);
   localparam logic [PRE_W-1:0]  LAST_PRE  = PRE_W'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [BIN_W-1:0]  bin_q, bin_d;
   logic [15:0]       scratch_q, scratch_d;
   logic [15:0]       adjusted;
   logic [ITER_W-1:0] iter_q, iter_d;
   logic              ovf_q, ovf_d;
   logic [15:0]       disp_q, disp_d;
   logic              done_q, done_d;
   logic [PRE_W-1:0]  presc_q, presc_d;
   logic [1:0]        digit_q, digit_d;

   // Add-3 correction applied to every BCD nibble before the shift.
   always_comb begin
      adjusted = scratch_q;
      for (int n = 0; n < 4; n++) begin
         if (scratch_q[4*n +: 4] >= 4'd5) begin
            adjusted[4*n +: 4] = scratch_q[4*n +: 4] + 4'd3;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      bin_d     = bin_q;
      scratch_d = scratch_q;
      iter_d    = iter_q;
      ovf_d     = ovf_q;
      disp_d    = disp_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (load) begin
               if (bin_in > MAX_VAL) begin
                  bin_d = MAX_VAL;
                  ovf_d = 1'b1;
               end else begin
                  bin_d = bin_in;
                  ovf_d = 1'b0;
               end
               scratch_d = 16'h0000;
               iter_d    = '0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            // The clamp to 9999 means the bit shifted out of the thousands nibble is always zero.
            {scratch_d, bin_d} = {adjusted, bin_q} << 1;
            iter_d = iter_q + 1'b1;
            if (iter_q == LAST_ITER) begin
               state_d = DONE;
            end
         end
         DONE: begin
            disp_d  = scratch_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      presc_d = presc_q + 1'b1;
      digit_d = digit_q;
      if (presc_q == LAST_PRE) begin
         presc_d = '0;
         digit_d = digit_q + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         bin_q     <= '0;
         scratch_q <= 16'h0000;
         iter_q    <= '0;
         ovf_q     <= 1'b0;
         disp_q    <= 16'h0000;
         done_q    <= 1'b0;
         presc_q   <= '0;
         digit_q   <= 2'd0;
      end else begin
         state_q   <= state_d;
         bin_q     <= bin_d;
         scratch_q <= scratch_d;
         iter_q    <= iter_d;
         ovf_q     <= ovf_d;
         disp_q    <= disp_d;
         done_q    <= done_d;
         presc_q   <= presc_d;
         digit_q   <= digit_d;
      end
   end

   assign busy                     = (state_q != IDLE);
   assign done                     = done_q;
   assign overflow                 = ovf_q;
   assign displayed_number         = disp_q;
   assign digit_activating_counter = digit_q;

endmodule

// File: tb/tb_bcd_display_feeder.sv
// Self-checking bench for bcd_display_feeder: table vectors, random values against a
// decimal-arithmetic model, and hand-written multi-cycle sequences.
module tb_bcd_display_feeder;

   localparam int BIN_W = 14;
   localparam int RDIV  = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             load;
   logic [BIN_W-1:0] bin_in;
   logic             busy;
   logic             done;
   logic             overflow;
   logic [15:0]      displayed_number;
   logic [1:0]       digit_activating_counter;

   int total = 0;
   int bad   = 0;
   int edgeCnt = 0;
   logic [15:0] prevDisp = 16'h0000;

   typedef struct {
      int          val;
      logic [15:0] expDisp;
      logic        expOvf;
   } vec_t;

   vec_t vecs[6];

   bcd_display_feeder #(.BIN_W(BIN_W), .REFRESH_DIV(RDIV)) dut (
      .clk                      (clk),
      .rst_n                    (rst_n),
      .load                     (load),
      .bin_in                   (bin_in),
      .busy                     (busy),
      .done                     (done),
      .overflow                 (overflow),
      .displayed_number         (displayed_number),
      .digit_activating_counter (digit_activating_counter)
   );

   always #5 clk = ~clk;

   // Edges since the most recent reset edge; drives the refresh expectation.
   always @(posedge clk) begin
      if (!rst_n) edgeCnt = 0;
      else        edgeCnt = edgeCnt + 1;
   end

   function automatic logic [15:0] bcdOf(input int v);
      int c;
      c = (v > 9999) ? 9999 : v;
      return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issue one load and follow it for 20 cycles; optionally inject a second load mid-conversion.
   task automatic applyStimulus(input int val, input logic [15:0] expDisp, input logic expOvf,
                                input int extraAt, input int extraVal);
      int doneAt;
      int doneCount;
      logic midStable;
      logic busyAt14;
      logic busyAt15;
      doneAt = 0; doneCount = 0; midStable = 1'b1; busyAt14 = 1'b0; busyAt15 = 1'b1;
      @(negedge clk);
      load = 1'b1; bin_in = BIN_W'(val);
      @(negedge clk);
      load = 1'b0;
      checkOutput("busyAfterLoad", int'(busy), 1);
      checkOutput("ovfAtLoad", int'(overflow), int'(expOvf));
      for (int k = 1; k <= 20; k++) begin
         if (k == extraAt) begin
            load = 1'b1; bin_in = BIN_W'(extraVal);
         end else begin
            load = 1'b0;
         end
         @(negedge clk);
         if (done) begin
            doneCount++;
            if (doneAt == 0) doneAt = k;
         end
         if (k < 15 && displayed_number != prevDisp) midStable = 1'b0;
         if (k == 14) busyAt14 = busy;
         if (k == 15) busyAt15 = busy;
      end
      load = 1'b0;
      checkOutput("doneLatency", doneAt, 15);
      checkOutput("donePulses", doneCount, 1);
      checkOutput("oldValueHeld", int'(midStable), 1);
      checkOutput("busyAtEdge14", int'(busyAt14), 1);
      checkOutput("busyAtEdge15", int'(busyAt15), 0);
      checkOutput("result", int'(displayed_number), int'(expDisp));
      checkOutput("ovfAfter", int'(overflow), int'(expOvf));
      prevDisp = expDisp;
   endtask

   initial begin
      int waitCnt;
      int v;
      vecs[0] = '{1234,  16'h1234, 1'b0};
      vecs[1] = '{0,     16'h0000, 1'b0};
      vecs[2] = '{9999,  16'h9999, 1'b0};
      vecs[3] = '{10000, 16'h9999, 1'b1};
      vecs[4] = '{16383, 16'h9999, 1'b1};
      vecs[5] = '{7,     16'h0007, 1'b0};

      rst_n = 1'b0; load = 1'b0; bin_in = '0;
      repeat (2) @(negedge clk);
      checkOutput("rstBusy", int'(busy), 0);
      checkOutput("rstDone", int'(done), 0);
      checkOutput("rstOvf", int'(overflow), 0);
      checkOutput("rstDisp", int'(displayed_number), 0);
      checkOutput("rstDigit", int'(digit_activating_counter), 0);

      // Refresh sequence with a conversion started partway through.
      rst_n = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         load = (i == 10);
         bin_in = BIN_W'(555);
         @(negedge clk);
         checkOutput("digitSlot", int'(digit_activating_counter), (edgeCnt / RDIV) % 4);
      end
      load = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("refreshConv", int'(displayed_number), 16'h0555);
      prevDisp = 16'h0555;

      foreach (vecs[i]) applyStimulus(vecs[i].val, vecs[i].expDisp, vecs[i].expOvf, 0, 0);

      for (int i = 0; i < 8; i++) begin
         v = int'($urandom_range(0, 16383));
         applyStimulus(v, bcdOf(v), v > 9999, 0, 0);
      end

      // Second load during the conversion is ignored.
      applyStimulus(4321, 16'h4321, 1'b0, 5, 1111);

      // Back-to-back: load presented in the done cycle of the previous conversion.
      @(negedge clk);
      load = 1'b1; bin_in = BIN_W'(300);
      @(negedge clk);
      load = 1'b0;
      waitCnt = 0;
      while (!done && waitCnt < 20) begin
         @(negedge clk);
         waitCnt++;
      end
      checkOutput("b2bFirstDone", int'(done), 1);
      checkOutput("b2bFirstVal", int'(displayed_number), 16'h0300);
      load = 1'b1; bin_in = BIN_W'(58);
      @(negedge clk);
      load = 1'b0;
      checkOutput("b2bAccepted", int'(busy), 1);
      repeat (14) @(negedge clk);
      checkOutput("b2bNotYet", int'(done), 0);
      @(negedge clk);
      checkOutput("b2bDone", int'(done), 1);
      checkOutput("b2bVal", int'(displayed_number), 16'h0058);

      // Reset during a conversion.
      @(negedge clk);
      load = 1'b1; bin_in = BIN_W'(9876);
      @(negedge clk);
      load = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("midRstBusy", int'(busy), 0);
      checkOutput("midRstDone", int'(done), 0);
      checkOutput("midRstOvf", int'(overflow), 0);
      checkOutput("midRstDisp", int'(displayed_number), 0);
      checkOutput("midRstDigit", int'(digit_activating_counter), 0);
      rst_n = 1'b1;
      waitCnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) waitCnt++;
      end
      checkOutput("midRstNoDone", waitCnt, 0);
      prevDisp = 16'h0000;
      applyStimulus(42, 16'h0042, 1'b0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
